// File: rtl/pic_command_sequencer.sv
// PIC init/operation command sequencer: sync CPU strobes, commit writes, decode ICW/OCW.
// Optional IMR read-back path enabled by defining PIC_IMR_READBACK_EN.
module pic_command_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  chip_select,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic                  A0,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic [DATA_WIDTH-1:0] internal_data_bus,
  output logic                  ICW1,
  output logic                  ICW2,
  output logic                  ICW3,
  output logic                  ICW4,
  output logic                  OCW1,
  output logic                  OCW2,
  output logic                  OCW3,
  output logic                  read,
  output logic                  single_mode,
  output logic                  icw4_needed,
  output logic                  init_done,
  output logic                  seq_error,
  output logic [DATA_WIDTH-1:0] read_data
);

  typedef enum logic [2:0] {
    S_UNINIT,
    S_WAIT2,
    S_WAIT3,
    S_WAIT4,
    S_READY
  } state_t;

  state_t r_state;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_we_sync;
  logic [SYNC_STAGES-1:0] r_re_sync;
  logic [SYNC_STAGES-1:0] r_a0_sync;
  logic [DATA_WIDTH-1:0]  r_d_sync [SYNC_STAGES];

  logic                  r_hold_a0;
  logic [DATA_WIDTH-1:0] r_hold_d;
  logic                  r_wr_prev;
  logic                  r_ovl_prev;

  logic                  w_cs_s;
  logic                  w_we_s;
  logic                  w_re_s;
  logic                  w_a0_s;
  logic [DATA_WIDTH-1:0] w_d_s;
  logic                  w_wr_act;
  logic                  w_rd_act;
  logic                  w_ovl;
  logic                  w_commit;
  logic                  w_c1;
  logic                  w_c2;
  logic                  w_c3;
  logic                  w_cd;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cs_sync <= '1;
      r_we_sync <= '1;
      r_re_sync <= '1;
      r_a0_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++)
        r_d_sync[i] <= '0;
    end else begin
      r_cs_sync[0] <= chip_select;
      r_we_sync[0] <= write_enable;
      r_re_sync[0] <= read_enable;
      r_a0_sync[0] <= A0;
      r_d_sync[0]  <= input_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_cs_sync[i] <= r_cs_sync[i-1];
        r_we_sync[i] <= r_we_sync[i-1];
        r_re_sync[i] <= r_re_sync[i-1];
        r_a0_sync[i] <= r_a0_sync[i-1];
        r_d_sync[i]  <= r_d_sync[i-1];
      end
    end
  end

  assign w_cs_s = r_cs_sync[SYNC_STAGES-1];
  assign w_we_s = r_we_sync[SYNC_STAGES-1];
  assign w_re_s = r_re_sync[SYNC_STAGES-1];
  assign w_a0_s = r_a0_sync[SYNC_STAGES-1];
  assign w_d_s  = r_d_sync[SYNC_STAGES-1];

  assign w_wr_act = ~w_cs_s & ~w_we_s;
  assign w_rd_act = ~w_cs_s & ~w_re_s;
  assign w_ovl    = w_wr_act & w_rd_act;
  assign w_commit = r_wr_prev & ~w_wr_act;

  // Command class comes from the holding registers, frozen once wr_act drops
  assign w_c1 = ~r_hold_a0 &  r_hold_d[4];
  assign w_c2 = ~r_hold_a0 & ~r_hold_d[4] & ~r_hold_d[3];
  assign w_c3 = ~r_hold_a0 & ~r_hold_d[4] &  r_hold_d[3];
  assign w_cd =  r_hold_a0;

  assign init_done = (r_state == S_READY);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state           <= S_UNINIT;
      r_hold_a0         <= 1'b1;
      r_hold_d          <= '0;
      r_wr_prev         <= 1'b0;
      r_ovl_prev        <= 1'b0;
      internal_data_bus <= '0;
      single_mode       <= 1'b0;
      icw4_needed       <= 1'b0;
      read              <= 1'b0;
      seq_error         <= 1'b0;
      ICW1 <= 1'b0;
      ICW2 <= 1'b0;
      ICW3 <= 1'b0;
      ICW4 <= 1'b0;
      OCW1 <= 1'b0;
      OCW2 <= 1'b0;
      OCW3 <= 1'b0;
    end else begin
      ICW1 <= 1'b0;
      ICW2 <= 1'b0;
      ICW3 <= 1'b0;
      ICW4 <= 1'b0;
      OCW1 <= 1'b0;
      OCW2 <= 1'b0;
      OCW3 <= 1'b0;
      r_wr_prev  <= w_wr_act;
      r_ovl_prev <= w_ovl;
      read       <= w_rd_act & ~w_wr_act;
      seq_error  <= w_ovl & ~r_ovl_prev;
      if (w_wr_act) begin
        r_hold_a0 <= w_a0_s;
        r_hold_d  <= w_d_s;
      end
      if (w_commit) begin
        internal_data_bus <= r_hold_d;
        if (w_c1) begin
          ICW1        <= 1'b1;
          single_mode <= r_hold_d[1];
          icw4_needed <= r_hold_d[0];
          r_state     <= S_WAIT2;
        end else begin
          unique case (r_state)
            S_UNINIT: seq_error <= 1'b1;
            S_WAIT2: begin
              if (w_cd) begin
                ICW2 <= 1'b1;
                if (!single_mode)
                  r_state <= S_WAIT3;
                else if (icw4_needed)
                  r_state <= S_WAIT4;
                else
                  r_state <= S_READY;
              end else begin
                seq_error <= 1'b1;
              end
            end
            S_WAIT3: begin
              if (w_cd) begin
                ICW3 <= 1'b1;
                r_state <= icw4_needed ? S_WAIT4
                                       : S_READY;
              end else begin
                seq_error <= 1'b1;
              end
            end
            S_WAIT4: begin
              if (w_cd) begin
                ICW4    <= 1'b1;
                r_state <= S_READY;
              end else begin
                seq_error <= 1'b1;
              end
            end
            S_READY: begin
              unique case (1'b1)
                w_cd:    OCW1 <= 1'b1;
                w_c2:    OCW2 <= 1'b1;
                w_c3:    OCW3 <= 1'b1;
                default: ;
              endcase
            end
            default: r_state <= S_UNINIT;
          endcase
        end
      end
    end
  end

`ifdef PIC_IMR_READBACK_EN
  logic [DATA_WIDTH-1:0] r_imr;
  logic [DATA_WIDTH-1:0] r_read_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_imr       <= '0;
      r_read_data <= '0;
    end else begin
      if (ICW1)
        r_imr <= '0;
      else if (OCW1)
        r_imr <= internal_data_bus;
      r_read_data <= (w_rd_act & ~w_wr_act & w_a0_s)
                     ? r_imr : '0;
    end
  end

  assign read_data = r_read_data;
`else
  assign read_data = '0;
`endif

endmodule
